fpu_div_iter: RTL and testbench

FPU_DIV_ITER -- requirements
Module: fpu_div_iter

---
 rtl/fpu_div_iter.sv | 221 ++++++++++++++++++++++
 tb/tb_fpu_div_iter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fpu_div_iter.sv
// Iterative IEEE-754 single-precision divider: 26-cycle restoring mantissa divide, normalise, pack.
// Optional round-to-nearest-even is enabled by defining FPU_DIV_ROUND_EN (truncation otherwise).
module fpu_div_iter #(
    parameter int SIZE_EXP = 8,
    parameter int SIZE_MAN = 23
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [SIZE_EXP+SIZE_MAN:0]     i_data_a,
    input  logic [SIZE_EXP+SIZE_MAN:0]     i_data_b,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [SIZE_EXP+SIZE_MAN:0]     o_data,
    output logic                           o_div_zero
);

    localparam int W    = 1 + SIZE_EXP + SIZE_MAN;
    localparam int EW   = SIZE_EXP + 2;
    localparam int MW   = SIZE_MAN + 1;
    localparam int QW   = SIZE_MAN + 3;
    localparam int CW   = $clog2(QW);
    localparam int BIAS = (1 << (SIZE_EXP - 1)) - 1;
    localparam int EMAX = (1 << SIZE_EXP) - 1;

    localparam logic signed [EW-1:0] EXP_MAX  = EW'(EMAX);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic [W-1:0] QNAN = {1'b0, {SIZE_EXP{1'b1}}, 1'b1, {(SIZE_MAN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;
    typedef enum logic [2:0] {C_NUM, C_NAN, C_INF, C_ZERO, C_DIVZ} cls_t;

    state_t                r_state;
    cls_t                  r_cls;
    logic [CW-1:0]         r_cnt;
    logic                  r_norm_ph;
    logic                  r_sign;
    logic signed [EW-1:0]  r_exp;
    logic signed [EW-1:0]  r_exp_n;
    logic [MW-1:0]         r_divisor;
    logic [QW-1:0]         r_rem;
    logic [QW-1:0]         r_quo;
    logic [SIZE_MAN-1:0]   r_frac;
`ifdef FPU_DIV_ROUND_EN
    logic                  r_guard;
    logic                  r_sticky;
`endif
    logic                  r_valid;
    logic [W-1:0]          r_data;
    logic                  r_div_zero;

    // Handshake: an operand pair transfers on a rising edge with i_valid & o_ready;
    // a quotient transfers on a rising edge with o_valid & i_ready, and o_valid/o_data/o_div_zero
    // hold stable until that edge. Neither side may make its valid depend on the other's ready.
    assign o_ready    = (r_state == S_IDLE);
    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_div_zero = r_div_zero;

    // Operand decode
    logic [SIZE_EXP-1:0] w_ea, w_eb;
    logic [SIZE_MAN-1:0] w_fa, w_fb;
    logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic w_sign;
    logic signed [EW-1:0] w_exp_in;
    cls_t w_cls;

    assign w_ea     = i_data_a[W-2 -: SIZE_EXP];
    assign w_eb     = i_data_b[W-2 -: SIZE_EXP];
    assign w_fa     = i_data_a[SIZE_MAN-1:0];
    assign w_fb     = i_data_b[SIZE_MAN-1:0];
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == {SIZE_EXP{1'b1}}) && (w_fa == '0);
    assign w_b_inf  = (w_eb == {SIZE_EXP{1'b1}}) && (w_fb == '0);
    assign w_a_nan  = (w_ea == {SIZE_EXP{1'b1}}) && (w_fa != '0);
    assign w_b_nan  = (w_eb == {SIZE_EXP{1'b1}}) && (w_fb != '0);
    assign w_sign   = i_data_a[W-1] ^ i_data_b[W-1];
    assign w_exp_in = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + EW'(BIAS);

    // Exponent-0 operands count as zero, so subnormals never reach the datapath
    always_comb begin
        w_cls = C_NUM;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf))
            w_cls = C_NAN;
        else if (w_a_inf)
            w_cls = C_INF;
        else if (w_b_zero)
            w_cls = C_DIVZ;
        else if (w_b_inf || w_a_zero)
            w_cls = C_ZERO;
    end

    // One restoring-divide step
    logic [QW-1:0] w_divisor_ext;
    logic          w_ge;
    logic [QW-1:0] w_rem_sel;
    logic [QW-1:0] w_rem_next;

    assign w_divisor_ext = {{(QW-MW){1'b0}}, r_divisor};
    assign w_ge          = (r_rem >= w_divisor_ext);
    assign w_rem_sel     = w_ge ? (r_rem - w_divisor_ext) : r_rem;
    assign w_rem_next    = w_rem_sel << 1;

    // Rounding and final packing (second NORM cycle)
    logic                  w_inc;
    logic [SIZE_MAN:0]     w_frac_rnd;
    logic                  w_carry;
    logic signed [EW-1:0]  w_exp_f;
    logic [W-1:0]          w_result;

`ifdef FPU_DIV_ROUND_EN
    assign w_inc = r_guard & (r_sticky | r_frac[0]);
`else
    assign w_inc = 1'b0;
`endif
    // A carry out of the fraction leaves it all-zero, which is exactly 1.0 at the next exponent
    assign w_frac_rnd = {1'b0, r_frac} + {{SIZE_MAN{1'b0}}, w_inc};
    assign w_carry    = w_frac_rnd[SIZE_MAN];
    assign w_exp_f    = r_exp_n + $signed({{(EW-1){1'b0}}, w_carry});

    always_comb begin
        w_result = '0;
        case (r_cls)
            C_NAN:         w_result = QNAN;
            C_INF, C_DIVZ: w_result = {r_sign, {SIZE_EXP{1'b1}}, {SIZE_MAN{1'b0}}};
            C_ZERO:        w_result = {r_sign, {(W-1){1'b0}}};
            default: begin
                if (w_exp_f >= EXP_MAX)
                    w_result = {r_sign, {SIZE_EXP{1'b1}}, {SIZE_MAN{1'b0}}};
                else if (w_exp_f <= EXP_ZERO)
                    w_result = {r_sign, {(W-1){1'b0}}};
                else
                    w_result = {r_sign, w_exp_f[SIZE_EXP-1:0], w_frac_rnd[SIZE_MAN-1:0]};
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cls      <= C_NUM;
            r_cnt      <= '0;
            r_norm_ph  <= 1'b0;
            r_sign     <= 1'b0;
            r_exp      <= '0;
            r_exp_n    <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_frac     <= '0;
`ifdef FPU_DIV_ROUND_EN
            r_guard    <= 1'b0;
            r_sticky   <= 1'b0;
`endif
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_cls     <= w_cls;
                        r_sign    <= w_sign;
                        r_exp     <= w_exp_in;
                        r_rem     <= {{(QW-MW){1'b0}}, 1'b1, w_fa};
                        r_divisor <= {1'b1, w_fb};
                        r_quo     <= '0;
                        r_cnt     <= '0;
                        r_state   <= S_DIV;
                    end
                end
                // Specials still run the full divide so latency never depends on the operands
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[QW-2:0], w_ge};
                    if (r_cnt == CW'(QW - 1)) begin
                        r_norm_ph <= 1'b0;
                        r_state   <= S_NORM;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_NORM: begin
                    if (!r_norm_ph) begin
                        r_norm_ph <= 1'b1;
                        if (r_quo[QW-1]) begin
                            r_frac  <= r_quo[QW-2:2];
                            r_exp_n <= r_exp;
`ifdef FPU_DIV_ROUND_EN
                            r_guard  <= r_quo[1];
                            r_sticky <= r_quo[0] | (r_rem != '0);
`endif
                        end else begin
                            r_frac  <= r_quo[QW-3:1];
                            r_exp_n <= r_exp - EW'(1);
`ifdef FPU_DIV_ROUND_EN
                            r_guard  <= r_quo[0];
                            r_sticky <= (r_rem != '0);
`endif
                        end
                    end else begin
                        r_data     <= w_result;
                        r_div_zero <= (r_cls == C_DIVZ);
                        r_valid    <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_div_iter.sv
// Directed bench for fpu_div_iter: reset state, latency, special operands, output hold and mid-op reset.
module tb_fpu_div_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_data_a = '0;
  logic [31:0] i_data_b = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_data;
  logic        o_div_zero;

  int n_cmp = 0;
  int n_err = 0;

`ifdef FPU_DIV_ROUND_EN
  localparam logic [31:0] EXP_THIRD    = 32'h3EAAAAAB;
  localparam logic [31:0] EXP_TWOTHIRD = 32'h3F2AAAAB;
`else
  localparam logic [31:0] EXP_THIRD    = 32'h3EAAAAAA;
  localparam logic [31:0] EXP_TWOTHIRD = 32'h3F2AAAAA;
`endif

  fpu_div_iter dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data_a   (i_data_a),
    .i_data_b   (i_data_b),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_div_zero (o_div_zero)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    int k;
    k = 0;
    @(negedge clk);
    while (!o_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_ready"}, {31'b0, o_ready}, 32'd1);
    i_valid  = 1'b1;
    i_data_a = a;
    i_data_b = b;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (o_valid) begin
        lat = n;
        break;
      end
    end
    check_eq({tag, "_latency"}, lat, 32'd28);
  endtask

  task automatic finish_op(input string tag);
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, {31'b0, o_valid}, 32'd0);
    check_eq({tag, "_ready_back"}, {31'b0, o_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_q, input logic exp_dz);
    start_op(tag, a, b);
    wait_result(tag);
    check_eq({tag, "_data"}, o_data, exp_q);
    check_eq({tag, "_dz"}, {31'b0, o_div_zero}, {31'b0, exp_dz});
    finish_op(tag);
  endtask

  initial begin
    logic seen;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'b0, o_ready}, 32'd1);
    check_eq("rst_valid", {31'b0, o_valid}, 32'd0);
    check_eq("rst_data", o_data, 32'h0);
    check_eq("rst_dz", {31'b0, o_div_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // normal numbers and rounding
    run_op("div_6_2",      32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    run_op("div_1_3",      32'h3F800000, 32'h40400000, EXP_THIRD,    1'b0);
    run_op("div_1_1p5",    32'h3F800000, 32'h3FC00000, EXP_TWOTHIRD, 1'b0);
    run_op("div_1_1",      32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);
    run_op("div_m1p5_0p5", 32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0);
    run_op("div_2_m2",     32'h40000000, 32'hC0000000, 32'hBF800000, 1'b0);
    // exponent range boundaries
    run_op("div_ovf",      32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0);
    run_op("div_maxexp",   32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0);
    run_op("div_minnorm",  32'h00800000, 32'h3F800000, 32'h00800000, 1'b0);
    run_op("div_unf_edge", 32'h00800000, 32'h40000000, 32'h00000000, 1'b0);
    run_op("div_unf",      32'h00800000, 32'h7F000000, 32'h00000000, 1'b0);
    // special operands
    run_op("div_1_0",      32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1);
    run_op("div_0_0",      32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0);
    run_op("div_nan_1",    32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0);
    run_op("div_inf_inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0);
    run_op("div_inf_2",    32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0);
    run_op("div_minf_0",   32'hFF800000, 32'h00000000, 32'hFF800000, 1'b0);
    run_op("div_m1_inf",   32'hBF800000, 32'h7F800000, 32'h80000000, 1'b0);
    run_op("div_0_5",      32'h00000000, 32'h40A00000, 32'h00000000, 1'b0);
    run_op("div_sub_1",    32'h00400000, 32'h3F800000, 32'h00000000, 1'b0);
    run_op("div_1_msub",   32'h3F800000, 32'h80400000, 32'hFF800000, 1'b1);

    // output held while downstream stalls, new operands ignored
    start_op("hold", 32'h3F800000, 32'h40000000);
    wait_result("hold");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      i_valid  = 1'b1;
      i_data_a = $urandom_range(32'h3F800000, 32'h40FFFFFF);
      i_data_b = 32'h40400000;
      @(posedge clk);
      #1;
      check_eq("hold_data", o_data, 32'h3F000000);
      check_eq("hold_valid", {31'b0, o_valid}, 32'd1);
      check_eq("hold_ready", {31'b0, o_ready}, 32'd0);
    end
    @(negedge clk);
    i_valid = 1'b0;
    finish_op("hold");
    run_op("after_hold", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);

    // reset in the middle of the divide aborts the operation
    start_op("abort", 32'h3F800000, 32'h40400000);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_valid", {31'b0, o_valid}, 32'd0);
    check_eq("abort_ready", {31'b0, o_ready}, 32'd1);
    check_eq("abort_data", o_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (o_valid) seen = 1'b1;
    end
    check_eq("abort_no_result", {31'b0, seen}, 32'd0);
    run_op("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
